// File: rtl/pcs_transmit_pkg.sv
// Shared 1000BASE-X PCS transmit constants: special octets, their code groups
// in both running-disparity columns, FSM state encodings and the symbol payload.
package pcs_transmit_pkg;

  localparam int unsigned OCTET_W = 8;
  localparam int unsigned CODE_W  = 10;
  localparam int unsigned STATE_W = 6;

  // Octet values (HGF_EDCBA) of the symbols the transmitter inserts itself
  localparam logic [OCTET_W-1:0] OCT_K28_5 = 8'hBC;
  localparam logic [OCTET_W-1:0] OCT_K27_7 = 8'hFB;
  localparam logic [OCTET_W-1:0] OCT_K29_7 = 8'hFD;
  localparam logic [OCTET_W-1:0] OCT_K23_7 = 8'hF7;
  localparam logic [OCTET_W-1:0] OCT_D5_6  = 8'hC5;
  localparam logic [OCTET_W-1:0] OCT_D16_2 = 8'h50;

  // Code groups abcdeifghj, index 0 = RD-, index 1 = RD+
  localparam logic [CODE_W-1:0] K28_5_CODE [2] = '{10'b0011111010, 10'b1100000101};
  localparam logic [CODE_W-1:0] K27_7_CODE [2] = '{10'b1101101000, 10'b0010010111};
  localparam logic [CODE_W-1:0] K29_7_CODE [2] = '{10'b1011101000, 10'b0100010111};
  localparam logic [CODE_W-1:0] K23_7_CODE [2] = '{10'b1110101000, 10'b0001010111};
  localparam logic [CODE_W-1:0] D5_6_CODE  [2] = '{10'b1010010110, 10'b1010010110};
  localparam logic [CODE_W-1:0] D16_2_CODE [2] = '{10'b0110110101, 10'b1001000101};

  // State names the class of code group currently on the output
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 6'b000001,
    ST_SOP    = 6'b000010,
    ST_DATA   = 6'b000100,
    ST_EOP    = 6'b001000,
    ST_END_R  = 6'b010000,
    ST_END_R2 = 6'b100000
  } tx_state_e;

  typedef struct packed {
    logic                is_k;
    logic [OCTET_W-1:0]  octet;
  } pcs_sym_t;

  function automatic pcs_sym_t mk_sym(input logic is_k, input logic [OCTET_W-1:0] octet);
    pcs_sym_t s;
    s.is_k  = is_k;
    s.octet = octet;
    return s;
  endfunction

endpackage

// File: rtl/encoder_8b10b.sv
// Combinational 8b/10b encoder: 5b/6b and 3b/4b sub-blocks with running
// disparity, D.x.7 alternate (A7) selection and the K28/Kx.7 control set.
module encoder_8b10b
  import pcs_transmit_pkg::*;
(
  input  logic [OCTET_W-1:0] data,
  input  logic               is_k,
  input  logic               rd_in,
  output logic [CODE_W-1:0]  code,
  output logic               rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] six_n;
  logic [5:0] six;
  logic [3:0] four_n;
  logic [3:0] four;
  logic       six_unbal;
  logic       four_unbal;
  logic       rd_mid;
  logic       alt7;

  assign x = data[4:0];
  assign y = data[7:5];

  // abcdei in the RD- column
  always_comb begin
    six_n = 6'b000000;
    case (x)
      5'd0:  six_n = 6'b100111;  5'd1:  six_n = 6'b011101;
      5'd2:  six_n = 6'b101101;  5'd3:  six_n = 6'b110001;
      5'd4:  six_n = 6'b110101;  5'd5:  six_n = 6'b101001;
      5'd6:  six_n = 6'b011001;  5'd7:  six_n = 6'b111000;
      5'd8:  six_n = 6'b111001;  5'd9:  six_n = 6'b100101;
      5'd10: six_n = 6'b010101;  5'd11: six_n = 6'b110100;
      5'd12: six_n = 6'b001101;  5'd13: six_n = 6'b101100;
      5'd14: six_n = 6'b011100;  5'd15: six_n = 6'b010111;
      5'd16: six_n = 6'b011011;  5'd17: six_n = 6'b100011;
      5'd18: six_n = 6'b010011;  5'd19: six_n = 6'b110010;
      5'd20: six_n = 6'b001011;  5'd21: six_n = 6'b101010;
      5'd22: six_n = 6'b011010;  5'd23: six_n = 6'b111010;
      5'd24: six_n = 6'b110011;  5'd25: six_n = 6'b100110;
      5'd26: six_n = 6'b010110;  5'd27: six_n = 6'b110110;
      5'd28: six_n = 6'b001110;  5'd29: six_n = 6'b101110;
      5'd30: six_n = 6'b011110;  5'd31: six_n = 6'b101011;
      default: six_n = 6'b000000;
    endcase
    if (is_k && (x == 5'd28)) six_n = 6'b001111;
  end

  assign six_unbal = ($countones(six_n) != 3);
  // D.7 is balanced but still has distinct RD columns
  assign six    = (rd_in && (six_unbal || (!is_k && (x == 5'd7)))) ? ~six_n : six_n;
  assign rd_mid = six_unbal ? ~rd_in : rd_in;

  // A7 avoids a run of five identical bits across the sub-block boundary
  assign alt7 = rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                       : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));

  // fghj in the RD- column (RD taken after the 6b sub-block)
  always_comb begin
    four_n = 4'b0000;
    if (is_k) begin
      case (y)
        3'd0: four_n = 4'b1011;  3'd1: four_n = 4'b0110;
        3'd2: four_n = 4'b1010;  3'd3: four_n = 4'b1100;
        3'd4: four_n = 4'b1101;  3'd5: four_n = 4'b0101;
        3'd6: four_n = 4'b1001;  3'd7: four_n = 4'b0111;
        default: four_n = 4'b0000;
      endcase
    end else begin
      case (y)
        3'd0: four_n = 4'b1011;  3'd1: four_n = 4'b1001;
        3'd2: four_n = 4'b0101;  3'd3: four_n = 4'b1100;
        3'd4: four_n = 4'b1101;  3'd5: four_n = 4'b1010;
        3'd6: four_n = 4'b0110;  3'd7: four_n = alt7 ? 4'b0111 : 4'b1110;
        default: four_n = 4'b0000;
      endcase
    end
  end

  assign four_unbal = ($countones(four_n) != 2);
  assign four   = (rd_mid && (four_unbal || is_k || (y == 3'd3))) ? ~four_n : four_n;
  assign code   = {six, four};
  assign rd_out = four_unbal ? ~rd_mid : rd_mid;

endmodule

// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: frames GMII octets with /S/ /T/ /R/, fills gaps
// with /I1/ /I2/ idles and registers one 8b/10b code group per cycle.
module pcs_transmit
  import pcs_transmit_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               xmit,
  input  logic               TX_EN,
  input  logic [OCTET_W-1:0] TXD,
  output logic [CODE_W-1:0]  tx_code_group,
  output logic               TX_EVEN,
  output logic               transmitting
);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic              rd;          // 1 = positive running disparity
  logic              next_even;   // parity of the slot produced at the next edge
  logic              idle_i1;     // RD was positive when the current idle set began
  pcs_sym_t          sym_c;
  logic              active_c;
  logic              idle_start_c;
  logic              idle_path_c;
  logic [CODE_W-1:0] enc_code;
  logic              enc_rd;

  encoder_8b10b u_enc (
    .data   (sym_c.octet),
    .is_k   (sym_c.is_k),
    .rd_in  (rd),
    .code   (enc_code),
    .rd_out (enc_rd)
  );

  // Next-state and symbol selection for the slot produced at the coming edge
  always_comb begin
    state_nxt    = state;
    sym_c        = mk_sym(1'b1, OCT_K28_5);
    active_c     = 1'b0;
    idle_start_c = 1'b0;
    idle_path_c  = 1'b0;
    case (state)
      ST_SOP, ST_DATA: begin
        active_c = 1'b1;
        if (TX_EN) begin
          sym_c     = mk_sym(1'b0, TXD);
          state_nxt = ST_DATA;
        end else begin
          sym_c     = mk_sym(1'b1, OCT_K29_7);
          state_nxt = ST_EOP;
        end
      end
      ST_EOP: begin
        active_c  = 1'b1;
        sym_c     = mk_sym(1'b1, OCT_K23_7);
        state_nxt = ST_END_R;
      end
      ST_END_R: begin
        // an /R/ on an even slot needs a partner so idles restart even
        if (TX_EVEN) begin
          active_c  = 1'b1;
          sym_c     = mk_sym(1'b1, OCT_K23_7);
          state_nxt = ST_END_R2;
        end else begin
          idle_path_c = 1'b1;
        end
      end
      default: idle_path_c = 1'b1;
    endcase

    if (idle_path_c) begin
      state_nxt = ST_IDLE;
      if (next_even) begin
        if (xmit && TX_EN) begin
          active_c  = 1'b1;
          sym_c     = mk_sym(1'b1, OCT_K27_7);
          state_nxt = ST_SOP;
        end else begin
          idle_start_c = 1'b1;
        end
      end else begin
        sym_c = mk_sym(1'b0, idle_i1 ? OCT_D5_6 : OCT_D16_2);
      end
    end
  end

  // State, disparity, slot parity and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      rd            <= 1'b0;
      next_even     <= 1'b1;
      idle_i1       <= 1'b0;
      tx_code_group <= '0;
      TX_EVEN       <= 1'b0;
      transmitting  <= 1'b0;
    end else begin
      state         <= state_nxt;
      rd            <= enc_rd;
      next_even     <= ~next_even;
      TX_EVEN       <= next_even;
      tx_code_group <= enc_code;
      transmitting  <= active_c;
      if (idle_start_c) idle_i1 <= rd;
    end
  end

endmodule

// File: tb/tb_pcs_transmit.sv
// Directed bench for pcs_transmit: a vector table of inputs and hand-derived
// code groups, plus a mid-frame reset sequence.
module tb_pcs_transmit;
  import pcs_transmit_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       xmit;
  logic       TX_EN;
  logic [7:0] TXD;
  logic [9:0] tx_code_group;
  logic       TX_EVEN;
  logic       transmitting;

  pcs_transmit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .xmit          (xmit),
    .TX_EN         (TX_EN),
    .TXD           (TXD),
    .tx_code_group (tx_code_group),
    .TX_EVEN       (TX_EVEN),
    .transmitting  (transmitting)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [9:0] D21_2  = 10'b1010100101;
  localparam logic [9:0] D21_6  = 10'b1010100110;
  localparam logic [9:0] D0_0N  = 10'b1001110100;
  localparam logic [9:0] D17_7N = 10'b1000110111;
  localparam logic [9:0] D11_7P = 10'b1101001000;
  localparam logic [9:0] D21_7N = 10'b1010101110;
  localparam logic [9:0] D7_7P  = 10'b0001110001;

  typedef struct {
    logic       rst;
    logic       xm;
    logic       en;
    logic [7:0] txd;
    logic [9:0] code;
    logic       even;
    logic       tx;
  } vec_t;

  vec_t vq[$];
  int   checks;
  int   errors;

  task automatic add(input logic r, input logic xm, input logic en, input logic [7:0] d,
                     input logic [9:0] c, input logic ev, input logic tx);
    vec_t v;
    v.rst = r; v.xm = xm; v.en = en; v.txd = d; v.code = c; v.even = ev; v.tx = tx;
    vq.push_back(v);
  endtask

  task automatic drive_step(input logic r, input logic xm, input logic en, input logic [7:0] d);
    RESET = r; xmit = xm; TX_EN = en; TXD = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [9:0] c, input logic ev, input logic tx);
    checks++;
    if (tx_code_group !== c) begin
      errors++;
      $display("FAIL %s code: got %b want %b", tag, tx_code_group, c);
    end
    checks++;
    if (TX_EVEN !== ev) begin
      errors++;
      $display("FAIL %s TX_EVEN: got %b want %b", tag, TX_EVEN, ev);
    end
    checks++;
    if (transmitting !== tx) begin
      errors++;
      $display("FAIL %s transmitting: got %b want %b", tag, transmitting, tx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    RESET = 1'b1; xmit = 1'b1; TX_EN = 1'b0; TXD = 8'h00;

    // reset hold and release into idle
    add(1, 1, 0, 8'h00, 10'b0,         0, 0);
    add(1, 1, 0, 8'h00, 10'b0,         0, 0);
    add(0, 1, 0, 8'h00, K28_5_CODE[0], 1, 0);
    add(0, 1, 0, 8'h00, D16_2_CODE[1], 0, 0);
    add(0, 1, 0, 8'h00, K28_5_CODE[0], 1, 0);
    // TX_EN first seen on an odd slot: octet dropped, /S/ next even slot
    add(0, 1, 1, 8'h55, D16_2_CODE[1], 0, 0);
    add(0, 1, 1, 8'h55, K27_7_CODE[0], 1, 1);
    add(0, 1, 1, 8'h55, D21_2,         0, 1);
    add(0, 1, 1, 8'h55, D21_2,         1, 1);
    add(0, 1, 1, 8'h55, D21_2,         0, 1);
    add(0, 1, 1, 8'h55, D21_2,         1, 1);
    add(0, 1, 1, 8'h55, D21_2,         0, 1);
    add(0, 1, 1, 8'h55, D21_2,         1, 1);
    add(0, 1, 1, 8'hD5, D21_6,         0, 1);
    // /T/ on even slot: single /R/
    add(0, 1, 0, 8'h00, K29_7_CODE[0], 1, 1);
    add(0, 1, 0, 8'h00, K23_7_CODE[0], 0, 1);
    add(0, 1, 0, 8'h00, K28_5_CODE[0], 1, 0);
    add(0, 1, 0, 8'h00, D16_2_CODE[1], 0, 0);
    // 0x00 payload (neutral D0.0), then D16.2 leaves RD positive; /T/ odd
    add(0, 1, 1, 8'h00, K27_7_CODE[0], 1, 1);
    add(0, 1, 1, 8'h00, D0_0N,         0, 1);
    add(0, 1, 1, 8'h00, D0_0N,         1, 1);
    add(0, 1, 1, 8'h00, D0_0N,         0, 1);
    add(0, 1, 1, 8'h50, D16_2_CODE[0], 1, 1);
    add(0, 1, 0, 8'h00, K29_7_CODE[1], 0, 1);
    add(0, 1, 0, 8'h00, K23_7_CODE[1], 1, 1);
    add(0, 1, 0, 8'h00, K23_7_CODE[1], 0, 1);
    add(0, 1, 0, 8'h00, K28_5_CODE[1], 1, 0);
    add(0, 1, 0, 8'h00, D5_6_CODE[1],  0, 0);
    add(0, 1, 0, 8'h00, K28_5_CODE[0], 1, 0);
    add(0, 1, 0, 8'h00, D16_2_CODE[1], 0, 0);
    // xmit=0 blocks SOP; xmit drop mid-frame does not truncate
    add(0, 0, 1, 8'h55, K28_5_CODE[0], 1, 0);
    add(0, 0, 1, 8'h55, D16_2_CODE[1], 0, 0);
    add(0, 1, 1, 8'h55, K27_7_CODE[0], 1, 1);
    add(0, 0, 1, 8'h55, D21_2,         0, 1);
    add(0, 0, 0, 8'h00, K29_7_CODE[0], 1, 1);
    add(0, 1, 1, 8'hAA, K23_7_CODE[0], 0, 1);
    add(0, 1, 0, 8'h00, K28_5_CODE[0], 1, 0);
    add(0, 1, 0, 8'h00, D16_2_CODE[1], 0, 0);
    // D.x.7 alternate and primary encodings
    add(0, 1, 1, 8'hF1, K27_7_CODE[0], 1, 1);
    add(0, 1, 1, 8'hF1, D17_7N,        0, 1);
    add(0, 1, 1, 8'hEB, D11_7P,        1, 1);
    add(0, 1, 1, 8'hF5, D21_7N,        0, 1);
    add(0, 1, 1, 8'hE7, D7_7P,         1, 1);
    add(0, 1, 0, 8'h00, K29_7_CODE[0], 0, 1);
    add(0, 1, 0, 8'h00, K23_7_CODE[0], 1, 1);
    add(0, 1, 0, 8'h00, K23_7_CODE[0], 0, 1);
    add(0, 1, 0, 8'h00, K28_5_CODE[0], 1, 0);

    foreach (vq[i]) begin
      drive_step(vq[i].rst, vq[i].xm, vq[i].en, vq[i].txd);
      check_out($sformatf("vec%0d", i), vq[i].code, vq[i].even, vq[i].tx);
    end

    // reset asserted mid-DATA: no /T/, outputs clear, restart on even K28.5 RD-
    drive_step(0, 1, 0, 8'h00);
    check_out("rst_pre_idle", D16_2_CODE[1], 0, 0);
    drive_step(0, 1, 1, 8'h55);
    check_out("rst_sop", K27_7_CODE[0], 1, 1);
    drive_step(0, 1, 1, 8'h55);
    check_out("rst_data", D21_2, 0, 1);
    drive_step(1, 1, 1, 8'h55);
    check_out("rst_assert", 10'b0, 0, 0);
    drive_step(1, 1, 1, 8'h55);
    check_out("rst_hold", 10'b0, 0, 0);
    drive_step(0, 1, 0, 8'h00);
    check_out("rst_release_k", K28_5_CODE[0], 1, 0);
    drive_step(0, 1, 0, 8'h00);
    check_out("rst_release_i2", D16_2_CODE[1], 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
